mmio_req_router: RTL and testbench

//  Sequences the CPU data-memory request interface (Address/MemRead/MemWrite/Read_data handshakes) between two targets:

---
 rtl/mmio_req_router.sv | 176 +++++++++++++++++
 tb/tb_mmio_req_router.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_req_router.sv
// CPU data-request sequencer: routes each request to main memory or the
// UART MMIO window, generates UART pulses and times out UART status reads.
module mmio_req_router #(
  parameter logic [15:0] UART_BASE = 16'h6000,
  parameter logic [3:0]  TX_OFF    = 4'h4,
  parameter logic [3:0]  STAT_OFF  = 4'h8,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] m_Address,
  output logic [31:0] m_Write_data,
  output logic [3:0]  m_Write_strb,
  output logic        m_MemWrite,
  output logic        m_MemRead,
  input  logic        m_Mem_Req_Ready,
  input  logic [31:0] m_Read_data,
  input  logic        m_Read_data_Valid,
  output logic        m_Read_data_Ready,
  output logic        uart_write_fifo,
  output logic [7:0]  uart_write_data,
  output logic        uart_read_state,
  input  logic        uart_read_ok,
  input  logic [31:0] uart_read_data,
  output logic        uart_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    UART_WR,
    UART_RQ,
    UART_WT,
    RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [31:0] rdata, rdata_d;
  logic        to_d;
  logic [7:0]  tx_byte, tx_byte_d;
  logic        tx_hit, tx_hit_d;

  logic       is_uart;
  logic       req;
  logic [3:0] off;

  assign is_uart = (Address[31:16] == UART_BASE);
  assign req     = MemRead | MemWrite;
  assign off     = Address[3:0];

  assign m_Address    = Address;
  assign m_Write_data = Write_data;
  assign m_Write_strb = Write_strb;

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rdata        <= '0;
      uart_timeout <= 1'b0;
      tx_byte      <= '0;
      tx_hit       <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      rdata        <= rdata_d;
      uart_timeout <= to_d;
      tx_byte      <= tx_byte_d;
      tx_hit       <= tx_hit_d;
    end
  end

  always_comb begin
    state_d           = state;
    cnt_d             = cnt;
    rdata_d           = rdata;
    to_d              = uart_timeout;
    tx_byte_d         = tx_byte;
    tx_hit_d          = tx_hit;
    Mem_Req_Ready     = 1'b0;
    Read_data         = '0;
    Read_data_Valid   = 1'b0;
    m_MemRead         = 1'b0;
    m_MemWrite        = 1'b0;
    m_Read_data_Ready = 1'b0;
    uart_write_fifo   = 1'b0;
    uart_write_data   = '0;
    uart_read_state   = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemRead & is_uart) begin
          Mem_Req_Ready = 1'b1;
          if (off == STAT_OFF) begin
            state_d = UART_RQ;
          end else begin
            rdata_d = '0;
            state_d = RESP;
          end
        end else if (MemWrite & is_uart) begin
          Mem_Req_Ready = 1'b1;
          tx_byte_d     = Write_data[7:0];
          tx_hit_d      = (off == TX_OFF);
          state_d       = UART_WR;
        end else if (req) begin
          m_MemRead     = MemRead;
          m_MemWrite    = MemWrite & ~MemRead;
          Mem_Req_Ready = m_Mem_Req_Ready;
          if (MemRead & m_Mem_Req_Ready)
            state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        Read_data         = m_Read_data;
        Read_data_Valid   = m_Read_data_Valid;
        m_Read_data_Ready = Read_data_Ready;
        if (m_Read_data_Valid & Read_data_Ready)
          state_d = IDLE;
      end
      UART_WR: begin
        uart_write_fifo = tx_hit;
        uart_write_data = tx_byte;
        state_d         = IDLE;
      end
      UART_RQ: begin
        uart_read_state = 1'b1;
        cnt_d           = '0;
        state_d         = UART_WT;
      end
      UART_WT: begin
        // data arriving on the terminal count still wins over timeout
        if (uart_read_ok) begin
          rdata_d = uart_read_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt + 8'd1;
          if (cnt_d == TO_LAST) begin
            rdata_d = '1;
            to_d    = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        Read_data       = rdata;
        Read_data_Valid = 1'b1;
        if (Read_data_Ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cpu_reset) begin
      Mem_Req_Ready     = 1'b0;
      Read_data         = '0;
      Read_data_Valid   = 1'b0;
      m_MemRead         = 1'b0;
      m_MemWrite        = 1'b0;
      m_Read_data_Ready = 1'b0;
      uart_write_fifo   = 1'b0;
      uart_write_data   = '0;
      uart_read_state   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_req_router.sv
// Randomized bench for mmio_req_router: transaction tasks set the expected
// outputs of every cycle from the routing rules; one process compares them.
module tb_mmio_req_router;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        cpu_reset;
  logic [31:0] Address;
  logic        MemWrite, MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid, Read_data_Ready;
  logic [31:0] m_Address, m_Write_data;
  logic [3:0]  m_Write_strb;
  logic        m_MemWrite, m_MemRead, m_Mem_Req_Ready;
  logic [31:0] m_Read_data;
  logic        m_Read_data_Valid, m_Read_data_Ready;
  logic        uart_write_fifo;
  logic [7:0]  uart_write_data;
  logic        uart_read_state, uart_read_ok;
  logic [31:0] uart_read_data;
  logic        uart_timeout;

  always #5 clk = ~clk;

  mmio_req_router #(.TO_CYCLES(TO)) dut (
    .cpu_clk(clk), .cpu_reset(cpu_reset),
    .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .m_Address(m_Address), .m_Write_data(m_Write_data),
    .m_Write_strb(m_Write_strb), .m_MemWrite(m_MemWrite),
    .m_MemRead(m_MemRead), .m_Mem_Req_Ready(m_Mem_Req_Ready),
    .m_Read_data(m_Read_data), .m_Read_data_Valid(m_Read_data_Valid),
    .m_Read_data_Ready(m_Read_data_Ready),
    .uart_write_fifo(uart_write_fifo), .uart_write_data(uart_write_data),
    .uart_read_state(uart_read_state), .uart_read_ok(uart_read_ok),
    .uart_read_data(uart_read_data), .uart_timeout(uart_timeout)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  bit chk_to = 0;
  bit model_to = 0;

  logic        e_ready, e_rvalid, e_mrd, e_mwr, e_mrdy;
  logic        e_wfifo, e_rstate;
  logic [31:0] e_rdata, e_addr, e_wd;
  logic [3:0]  e_strb;
  logic [7:0]  e_wbyte;

  logic [31:0] last_rd = '0;
  int n_fifo = 0;
  int n_rstate = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req_ready", Mem_Req_Ready, e_ready);
      chk("read_valid", Read_data_Valid, e_rvalid);
      if (e_rvalid) chk("read_data", Read_data, e_rdata);
      chk("m_memread", m_MemRead, e_mrd);
      chk("m_memwrite", m_MemWrite, e_mwr);
      if (e_mrd | e_mwr) begin
        chk("m_address", m_Address, e_addr);
        chk("m_write_data", m_Write_data, e_wd);
        chk("m_write_strb", m_Write_strb, e_strb);
      end
      chk("m_rd_ready", m_Read_data_Ready, e_mrdy);
      chk("uart_fifo", uart_write_fifo, e_wfifo);
      if (e_wfifo) chk("uart_wdata", uart_write_data, e_wbyte);
      chk("uart_rstate", uart_read_state, e_rstate);
      if (chk_to) chk("uart_timeout", uart_timeout, model_to);
    end
    if (uart_write_fifo === 1'b1) n_fifo++;
    if (uart_read_state === 1'b1) n_rstate++;
    if (Read_data_Valid === 1'b1 && Read_data_Ready === 1'b1)
      last_rd = Read_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear();
    e_ready = 0; e_rvalid = 0; e_mrd = 0; e_mwr = 0; e_mrdy = 0;
    e_wfifo = 0; e_rstate = 0; e_rdata = '0; e_addr = '0; e_wd = '0;
    e_strb = '0; e_wbyte = '0; chk_to = 1;
  endtask

  task automatic noise();
    MemRead = 0; MemWrite = 0;
    Address = $urandom; Write_data = $urandom; Write_strb = 4'($urandom);
    m_Mem_Req_Ready = 1'($urandom); m_Read_data = $urandom;
    m_Read_data_Valid = 1'($urandom); Read_data_Ready = 1'($urandom);
    uart_read_ok = 1'($urandom); uart_read_data = $urandom;
  endtask

  function automatic logic [31:0] mem_addr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:16] == 16'h6000) a[31:16] = 16'h0000;
    return a;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      noise(); exp_clear(); tick();
    end
  endtask

  task automatic do_reset();
    noise();
    cpu_reset = 1;
    MemRead = 1'($urandom); MemWrite = 1'($urandom);
    Address = {16'h6000, 16'($urandom)};
    exp_clear();
    chk_to = 0;
    tick();
    cpu_reset = 0;
    model_to = 0;
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] s, input int lat);
    for (int c = 0; c <= lat; c++) begin
      noise();
      MemWrite = 1; Address = addr; Write_data = d; Write_strb = s;
      m_Mem_Req_Ready = (c == lat);
      exp_clear();
      e_mwr = 1; e_ready = (c == lat);
      e_addr = addr; e_wd = d; e_strb = s;
      tick();
    end
  endtask

  task automatic mem_read(input logic [31:0] addr, input int lat,
                          input int vdel, input logic [31:0] d,
                          input int hold);
    bit v, r;
    for (int c = 0; c <= lat; c++) begin
      noise();
      MemRead = 1; Address = addr;
      m_Mem_Req_Ready = (c == lat);
      exp_clear();
      e_mrd = 1; e_ready = (c == lat);
      e_addr = addr; e_wd = Write_data; e_strb = Write_strb;
      tick();
    end
    for (int k = 0; k <= vdel + hold; k++) begin
      noise();
      MemWrite = 1'($urandom);
      Address = mem_addr();
      v = (k >= vdel);
      r = v ? (k >= vdel + hold) : 1'($urandom);
      m_Read_data_Valid = v;
      Read_data_Ready = r;
      if (v) m_Read_data = d;
      exp_clear();
      e_rvalid = v; e_rdata = m_Read_data; e_mrdy = r;
      tick();
    end
  endtask

  task automatic uart_write(input logic [31:0] addr, input logic [31:0] d);
    noise();
    MemWrite = 1; Address = addr; Write_data = d;
    exp_clear();
    e_ready = 1;
    tick();
    noise();
    exp_clear();
    e_wfifo = (addr[3:0] == 4'h4);
    e_wbyte = d[7:0];
    tick();
  endtask

  task automatic uart_read(input logic [31:0] addr, input int ok_at,
                           input logic [31:0] d, input int hold,
                           input bit wr_too, input int abort);
    logic [31:0] res;
    int nw;
    noise();
    MemRead = 1; MemWrite = wr_too; Address = addr;
    exp_clear();
    e_ready = 1;
    tick();
    res = '0;
    if (addr[3:0] == 4'h8) begin
      noise();
      uart_read_ok = 0;
      exp_clear();
      e_rstate = 1;
      tick();
      nw = (ok_at <= TO) ? ok_at : TO;
      res = (ok_at <= TO) ? d : 32'hFFFF_FFFF;
      for (int k = 1; k <= nw; k++) begin
        noise();
        uart_read_ok = (k == ok_at);
        if (k == ok_at) uart_read_data = d;
        if (abort == 1 && k == 2) begin
          do_reset();
          return;
        end
        exp_clear();
        tick();
      end
      if (ok_at > TO) model_to = 1;
    end
    for (int h = 0; h <= hold; h++) begin
      noise();
      Read_data_Ready = (h == hold);
      if (abort == 2 && h == 1) begin
        do_reset();
        return;
      end
      exp_clear();
      e_rvalid = 1; e_rdata = res;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int f0, r0, kind, ab;
    logic [3:0] o;
    noise();
    cpu_reset = 1;
    exp_clear();
    @(posedge clk);
    #1;
    chk_en = 1;
    do_reset();
    cpu_reset = 1;
    do_reset();

    f0 = n_fifo;
    uart_write(32'h6000_0004, 32'h0000_0041);
    chk("t1_pulses", n_fifo - f0, 1);
    f0 = n_fifo;
    uart_write(32'h6000_000C, 32'h0000_0055);
    chk("t2_pulses", n_fifo - f0, 0);
    idle(2);

    mem_read(32'h0000_1000, 3, 1, 32'hDEAD_BEEF, 2);
    chk("t3_data", last_rd, 32'hDEAD_BEEF);

    r0 = n_rstate;
    uart_read(32'h6000_0008, 4, 32'h0000_0005, 1, 0, 0);
    chk("t4_pulses", n_rstate - r0, 1);
    chk("t4_data", last_rd, 32'h0000_0005);
    chk("t4_timeout", uart_timeout, 0);

    uart_read(32'h6000_0008, 1000, 32'h1234_5678, 2, 0, 0);
    chk("t5_data", last_rd, 32'hFFFF_FFFF);
    chk("t5_timeout", uart_timeout, 1);
    idle(3);
    uart_read(32'h6000_0008, TO, 32'h0000_0077, 0, 0, 0);
    chk("t5_last_ok", last_rd, 32'h0000_0077);
    uart_read(32'h6000_0008, TO + 1, 32'h0000_0077, 0, 0, 0);
    chk("t5_one_late", last_rd, 32'hFFFF_FFFF);
    uart_read(32'h6000_0004, 1, 32'h0, 1, 1, 0);
    chk("other_offset", last_rd, 32'h0);

    uart_read(32'h6000_0008, 1000, 32'h0, 0, 0, 1);
    chk("t6_to_cleared", uart_timeout, 0);
    uart_read(32'h6000_0008, 2, 32'h0000_0009, 2, 0, 2);
    mem_write(32'h0000_0010, 32'hCAFE_F00D, 4'hF, 1);
    idle(2);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 5);
      o = ($urandom_range(0, 3) != 0) ? 4'h8 : 4'($urandom);
      case (kind)
        0: mem_write(mem_addr(), $urandom, 4'($urandom),
                     $urandom_range(0, 3));
        1: mem_read(mem_addr(), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, $urandom_range(0, 2));
        2: uart_write({16'h6000, 12'($urandom),
                       ($urandom_range(0, 1) != 0) ? 4'h4 : 4'($urandom)},
                      $urandom);
        3: uart_read({16'h6000, 12'($urandom), o}, $urandom_range(1, TO + 2),
                     $urandom, $urandom_range(0, 2), 1'($urandom), 0);
        4: idle($urandom_range(1, 3));
        default: begin
          ab = $urandom_range(1, 2);
          uart_read({16'h6000, 12'($urandom), 4'h8},
                    $urandom_range(3, TO + 2), $urandom,
                    $urandom_range(1, 2), 0, ab);
        end
      endcase
    end
    idle(2);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
